// File: rtl/fmul_fp32.sv
// IEEE-754 binary32 multiplier, round-to-nearest-even, flush-to-zero, canonical NaN.
// One registered output stage: result and valid appear one cycle after the operands.
module fmul_fp32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        valid_o,
  output logic [31:0] c_o
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Hidden bit is always 1, so only the fraction is rounded; bit 23 of the
  // result is the carry that means the significand became 2.0.
  function automatic logic [23:0] round_rne(input logic [22:0] frac,
                                            input logic        guard,
                                            input logic        sticky);
    logic up;
    up = guard & (sticky | frac[0]);
    return {1'b0, frac} + {23'h0, up};
  endfunction

  function automatic logic [31:0] pack_result(input logic              s,
                                              input logic signed [9:0] e,
                                              input logic [22:0]       frac);
    if (e >= 10'sd255)
      return {s, 8'hFF, 23'h0};
    else if (e <= 10'sd0)
      return {s, 31'h0};
    else
      return {s, e[7:0], frac};
  endfunction

  logic              w_a_zero, w_a_inf, w_a_nan;
  logic              w_b_zero, w_b_inf, w_b_nan;
  logic              w_sign;
  logic [47:0]       w_prod;
  logic signed [9:0] w_exp;
  logic [22:0]       w_frac_raw;
  logic              w_guard, w_sticky;
  logic [23:0]       w_rnd;
  logic [31:0]       w_c;

  logic              r_vld_p1;
  logic [31:0]       r_c_p1;

  always_comb begin
    w_a_zero = (a_i[30:23] == 8'h00);
    w_a_inf  = (a_i[30:23] == 8'hFF) && (a_i[22:0] == 23'h0);
    w_a_nan  = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'h0);
    w_b_zero = (b_i[30:23] == 8'h00);
    w_b_inf  = (b_i[30:23] == 8'hFF) && (b_i[22:0] == 23'h0);
    w_b_nan  = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'h0);
    w_sign   = a_i[31] ^ b_i[31];

    w_prod = 48'({1'b1, a_i[22:0]}) * 48'({1'b1, b_i[22:0]});
    w_exp  = $signed({2'b00, a_i[30:23]}) + $signed({2'b00, b_i[30:23]}) - 10'sd127;

    if (w_prod[47]) begin
      w_frac_raw = w_prod[46:24];
      w_guard    = w_prod[23];
      w_sticky   = |w_prod[22:0];
      w_exp      = w_exp + 10'sd1;
    end else begin
      w_frac_raw = w_prod[45:23];
      w_guard    = w_prod[22];
      w_sticky   = |w_prod[21:0];
    end

    w_rnd = round_rne(w_frac_raw, w_guard, w_sticky);
    if (w_rnd[23])
      w_exp = w_exp + 10'sd1;

    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf))
      w_c = QNAN;
    else if (w_a_inf || w_b_inf)
      w_c = {w_sign, 8'hFF, 23'h0};
    else if (w_a_zero || w_b_zero)
      w_c = {w_sign, 31'h0};
    else
      w_c = pack_result(w_sign, w_exp, w_rnd[22:0]);
  end

  // ---- stage p1: registered result ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p1 <= 1'b0;
      r_c_p1   <= 32'h0;
    end else begin
      r_vld_p1 <= valid_i;
      if (valid_i)
        r_c_p1 <= w_c;
    end
  end

  assign valid_o = r_vld_p1;
  assign c_o     = r_c_p1;

endmodule

// File: tb/tb_fmul_fp32.sv
// Directed self-checking bench for fmul_fp32 with hand-computed products.
module tb_fmul_fp32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] a_i, b_i;
  logic        valid_o;
  logic [31:0] c_o;

  int n_tests = 0;
  int n_fail  = 0;

  fmul_fp32 dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .valid_o (valid_o),
    .c_o     (c_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change on the falling edge; outputs are read on the falling edge
  // following the rising edge that captured them.
  task automatic test_reset();
    @(negedge clk_i);
    rst_i = 1'b1; valid_i = 1'b1; a_i = 32'h3F80_0000; b_i = 32'h3F80_0000;
    @(negedge clk_i);
    @(negedge clk_i);
    n_tests++;
    if (c_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_c: got %h want %h", c_o, 32'h0);
    end
    n_tests++;
    if (valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o);
    end
    rst_i = 1'b0; valid_i = 1'b0;
  endtask

  task automatic run_vectors(input string name, input logic [31:0] av[],
                             input logic [31:0] bv[], input logic [31:0] cv[]);
    for (int i = 0; i < av.size(); i++) begin
      @(negedge clk_i);
      valid_i = 1'b1; a_i = av[i]; b_i = bv[i];
      @(negedge clk_i);
      valid_i = 1'b0;
      n_tests++;
      if (c_o !== cv[i] || valid_o !== 1'b1) begin
        n_fail++;
        $display("FAIL %s[%0d] %h*%h: got c=%h v=%b want c=%h v=1",
                 name, i, av[i], bv[i], c_o, valid_o, cv[i]);
      end
    end
  endtask

  task automatic test_normal();
    logic [31:0] av[] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3FC0_0000, 32'hBF80_0000,
                          32'h3FFF_FFFF};
    logic [31:0] bv[] = '{32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000,
                          32'h3FFF_FFFF};
    logic [31:0] cv[] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'hC000_0000,
                          32'h407F_FFFE};
    run_vectors("normal", av, bv, cv);
  endtask

  task automatic test_special();
    logic [31:0] av[] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'h7F80_0000,
                          32'h7FC0_0000, 32'hFF80_0000, 32'h8000_0000, 32'h0000_0001,
                          32'h8000_0000};
    logic [31:0] bv[] = '{32'h4000_0000, 32'h3F80_0000, 32'h0000_0000, 32'hBF80_0000,
                          32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0000,
                          32'hBF80_0000};
    logic [31:0] cv[] = '{32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000, 32'hFF80_0000,
                          32'h7FC0_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000,
                          32'h0000_0000};
    run_vectors("special", av, bv, cv);
  endtask

  task automatic test_boundary();
    logic [31:0] av[] = '{32'h7F7F_FFFF, 32'h0080_0000, 32'h3F80_0001, 32'h0040_0000,
                          32'h3FFF_FFFF};
    logic [31:0] bv[] = '{32'h4000_0000, 32'h3F00_0000, 32'h3F80_0001, 32'h4000_0000,
                          32'h3F80_0001};
    logic [31:0] cv[] = '{32'h7F80_0000, 32'h0000_0000, 32'h3F80_0002, 32'h0000_0000,
                          32'h4000_0000};
    run_vectors("boundary", av, bv, cv);
  endtask

  task automatic test_hold();
    @(negedge clk_i);
    valid_i = 1'b1; a_i = 32'h3FC0_0000; b_i = 32'h4000_0000;
    @(negedge clk_i);
    valid_i = 1'b0; a_i = 32'hBF80_0000; b_i = 32'h4000_0000;
    @(negedge clk_i);
    @(negedge clk_i);
    n_tests++;
    if (c_o !== 32'h4040_0000 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL hold: got c=%h v=%b want c=40400000 v=0", c_o, valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av[] = '{32'h3F80_0000, 32'h3FC0_0000, 32'hBF80_0000, 32'h7F80_0000};
    logic [31:0] bv[] = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'hBF80_0000};
    logic [31:0] cv[] = '{32'h4000_0000, 32'h4040_0000, 32'hC000_0000, 32'hFF80_0000};
    for (int i = 0; i <= av.size(); i++) begin
      @(negedge clk_i);
      if (i > 0) begin
        n_tests++;
        if (c_o !== cv[i-1] || valid_o !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b[%0d]: got c=%h v=%b want c=%h v=1",
                   i - 1, c_o, valid_o, cv[i-1]);
        end
      end
      if (i < av.size()) begin
        valid_i = 1'b1; a_i = av[i]; b_i = bv[i];
      end
    end
    // Reset arrives together with a valid pair and must win.
    rst_i = 1'b1; valid_i = 1'b1; a_i = 32'h3F80_0000; b_i = 32'h3F80_0000;
    @(negedge clk_i);
    rst_i = 1'b0; valid_i = 1'b0;
    n_tests++;
    if (c_o !== 32'h0 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_override: got c=%h v=%b want c=00000000 v=0", c_o, valid_o);
    end
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; a_i = 32'h0; b_i = 32'h0;
    test_reset();
    test_normal();
    test_special();
    test_boundary();
    test_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
